// File: rtl/cpu_value_stack_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_value_stack_pkg : shared value-type tags, stack op codes, trap codes
// Revision: 1.0
// ----------------------------------------------------------------------------
package cpu_value_stack_pkg;

  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_BINOP = 3'd3;
  localparam logic [2:0] OP_UNOP  = 3'd4;
  localparam logic [2:0] OP_DROP2 = 3'd5;

  localparam logic [3:0] TRAP_NONE       = 4'd0;
  localparam logic [3:0] STACK_UNDERFLOW = 4'd1;
  localparam logic [3:0] STACK_OVERFLOW  = 4'd2;

  typedef struct packed {
    logic [1:0]  vtype;
    logic [63:0] data;
  } stack_entry_t;

endpackage
`default_nettype wire

// File: rtl/cpu_stack_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_stack_ram : 1 synchronous write port, 2 asynchronous read ports
// Revision: 1.0
// ----------------------------------------------------------------------------
module cpu_stack_ram
  import cpu_value_stack_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = $bits(stack_entry_t)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_b_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/cpu_value_stack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_value_stack : typed 64-bit operand stack with sticky under/overflow trap
// Revision: 1.0
// ----------------------------------------------------------------------------
module cpu_value_stack
  import cpu_value_stack_pkg::*;
#(
  parameter int DEPTH_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            op,
  input  logic [63:0]           data_in,
  input  logic [1:0]            type_in,
  output logic [63:0]           top,
  output logic [1:0]            top_type,
  output logic [63:0]           second,
  output logic [1:0]            second_type,
  output logic                  empty,
  output logic [DEPTH_ADDR:0]   size,
  output logic [3:0]            trap
);

  localparam logic [DEPTH_ADDR:0]   CAPACITY = {1'b1, {DEPTH_ADDR{1'b0}}};
  localparam logic [DEPTH_ADDR:0]   SP_ONE   = (DEPTH_ADDR+1)'(1);
  localparam logic [DEPTH_ADDR:0]   SP_TWO   = (DEPTH_ADDR+1)'(2);
  localparam logic [DEPTH_ADDR-1:0] PTR_ONE  = DEPTH_ADDR'(1);
  localparam logic [DEPTH_ADDR-1:0] PTR_TWO  = DEPTH_ADDR'(2);

  logic [DEPTH_ADDR:0]   sp_q, sp_d;
  logic [3:0]            trap_q, trap_d;
  logic                  we;
  logic [DEPTH_ADDR-1:0] waddr;
  logic [DEPTH_ADDR-1:0] addr_top, addr_second;
  stack_entry_t          wdata, rd_top, rd_second;

  assign wdata       = '{vtype: type_in, data: data_in};
  assign addr_top    = sp_q[DEPTH_ADDR-1:0] - PTR_ONE;
  assign addr_second = sp_q[DEPTH_ADDR-1:0] - PTR_TWO;

  always_comb begin
    sp_d   = sp_q;
    trap_d = trap_q;
    we     = 1'b0;
    waddr  = addr_top;
    // A nonzero trap freezes pointer and storage until reset.
    if (trap_q == TRAP_NONE) begin
      case (op)
        OP_PUSH: begin
          if (sp_q == CAPACITY) begin
            trap_d = STACK_OVERFLOW;
          end else begin
            we    = 1'b1;
            waddr = sp_q[DEPTH_ADDR-1:0];
            sp_d  = sp_q + SP_ONE;
          end
        end
        OP_POP: begin
          if (sp_q == '0) trap_d = STACK_UNDERFLOW;
          else            sp_d   = sp_q - SP_ONE;
        end
        OP_DROP2: begin
          if (sp_q < SP_TWO) trap_d = STACK_UNDERFLOW;
          else               sp_d   = sp_q - SP_TWO;
        end
        OP_BINOP: begin
          if (sp_q < SP_TWO) begin
            trap_d = STACK_UNDERFLOW;
          end else begin
            we    = 1'b1;
            waddr = addr_second;
            sp_d  = sp_q - SP_ONE;
          end
        end
        OP_UNOP: begin
          if (sp_q == '0) begin
            trap_d = STACK_UNDERFLOW;
          end else begin
            we    = 1'b1;
            waddr = addr_top;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q   <= '0;
      trap_q <= TRAP_NONE;
    end else begin
      sp_q   <= sp_d;
      trap_q <= trap_d;
    end
  end

  cpu_stack_ram #(
    .ADDR_W (DEPTH_ADDR),
    .WIDTH  ($bits(stack_entry_t))
  ) u_ram (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (addr_top),
    .rdata_a_o (rd_top),
    .raddr_b_i (addr_second),
    .rdata_b_o (rd_second)
  );

  // Reads past the live region return stale RAM data, so mask them here.
  assign top         = (sp_q != '0)    ? rd_top.data     : 64'd0;
  assign top_type    = (sp_q != '0)    ? rd_top.vtype    : TYPE_I32;
  assign second      = (sp_q >= SP_TWO) ? rd_second.data  : 64'd0;
  assign second_type = (sp_q >= SP_TWO) ? rd_second.vtype : TYPE_I32;
  assign empty       = (sp_q == '0);
  assign size        = sp_q;
  assign trap        = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_value_stack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cpu_value_stack : scoreboard bench with queue-based reference stack
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cpu_value_stack;

  localparam int DA  = 4;
  localparam int CAP = 16;

  typedef struct {
    logic [63:0] top;
    logic [1:0]  top_type;
    logic [63:0] second;
    logic [1:0]  second_type;
    logic        empty;
    logic [DA:0] size;
    logic [3:0]  trap;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [63:0] data_in = 64'd0;
  logic [1:0]  type_in = 2'd0;
  logic [63:0] top, second;
  logic [1:0]  top_type, second_type;
  logic        empty;
  logic [DA:0] size;
  logic [3:0]  trap;

  cpu_value_stack #(.DEPTH_ADDR(DA)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .data_in     (data_in),
    .type_in     (type_in),
    .top         (top),
    .top_type    (top_type),
    .second      (second),
    .second_type (second_type),
    .empty       (empty),
    .size        (size),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  // Reference model: a plain queue of {type,data} words plus a trap code.
  logic [65:0] model[$];
  int          mtrap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] o, input logic [63:0] d,
                      input logic [1:0] t, input string tag);
    exp_t e;
    logic [65:0] w;
    @(negedge clk);
    reset = rst; op = o; data_in = d; type_in = t;
    if (rst) begin
      model.delete();
      mtrap = 0;
    end else if (mtrap == 0) begin
      case (o)
        3'd1: if (model.size() == CAP) mtrap = 2; else model.push_back({t, d});
        3'd2: if (model.size() == 0) mtrap = 1; else w = model.pop_back();
        3'd5: if (model.size() < 2) mtrap = 1;
              else begin w = model.pop_back(); w = model.pop_back(); end
        3'd3: if (model.size() < 2) mtrap = 1;
              else begin w = model.pop_back(); w = model.pop_back(); model.push_back({t, d}); end
        3'd4: if (model.size() == 0) mtrap = 1;
              else begin w = model.pop_back(); model.push_back({t, d}); end
        default: ;
      endcase
    end
    e.tag         = tag;
    e.empty       = (model.size() == 0);
    e.size        = (DA+1)'(model.size());
    e.trap        = 4'(mtrap);
    e.top         = (model.size() > 0) ? model[model.size()-1][63:0]  : 64'd0;
    e.top_type    = (model.size() > 0) ? model[model.size()-1][65:64] : 2'd0;
    e.second      = (model.size() > 1) ? model[model.size()-2][63:0]  : 64'd0;
    e.second_type = (model.size() > 1) ? model[model.size()-2][65:64] : 2'd0;
    sbq.push_back(e);
  endtask

  // Monitor: every edge produces a visible result one cycle after sampling.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, ".top"},         top,          e.top);
        chk({e.tag, ".top_type"},    64'(top_type), 64'(e.top_type));
        chk({e.tag, ".second"},      second,       e.second);
        chk({e.tag, ".second_type"}, 64'(second_type), 64'(e.second_type));
        chk({e.tag, ".empty"},       64'(empty),   64'(e.empty));
        chk({e.tag, ".size"},        64'(size),    64'(e.size));
        chk({e.tag, ".trap"},        64'(trap),    64'(e.trap));
      end
    end
  end

  initial begin
    int r;
    logic [2:0] o;
    // Directed sequence
    step(1, 0, 0, 0, "reset");
    repeat (3) step(0, 0, 0, 0, "idle");
    step(0, 1, 64'd1, 2'd0, "push1");
    step(0, 1, 64'd2, 2'd0, "push2");
    step(0, 3, 64'd3, 2'd0, "binop");
    step(0, 1, 64'h1_0000_0000, 2'd1, "push64");
    step(0, 4, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, "unop");
    step(0, 2, 0, 0, "pop");
    step(0, 2, 0, 0, "pop");
    step(0, 6, 64'd9, 2'd2, "op6");
    step(1, 0, 0, 0, "reset");
    for (int i = 0; i < CAP; i++) step(0, 1, 64'(i), 2'(i), "fill");
    step(0, 4, 64'h55, 2'd3, "unop_full");
    step(0, 1, 64'd99, 2'd0, "push_ovf");
    step(0, 2, 0, 0, "pop_trapped");
    step(1, 0, 0, 0, "reset");
    step(0, 2, 0, 0, "pop_udf");
    step(1, 0, 0, 0, "reset");
    step(0, 1, 64'd42, 2'd1, "push");
    step(0, 3, 64'd5, 2'd0, "binop_udf");
    step(0, 1, 64'd6, 2'd0, "push_trapped");
    step(1, 0, 0, 0, "reset");
    step(0, 1, 64'd7, 2'd2, "push_f32");
    step(0, 1, 64'd8, 2'd3, "push_f64");
    step(0, 5, 0, 0, "drop2");
    step(0, 5, 0, 0, "drop2_udf");
    step(1, 0, 0, 0, "reset");
    // Random phase: push-biased so both ends of the stack are exercised
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (mtrap != 0 && r < 20) begin
        step(1, 0, 0, 0, "rnd_reset");
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 40)      o = 3'd1;
        else if (r < 55) o = 3'd2;
        else if (r < 67) o = 3'd3;
        else if (r < 79) o = 3'd4;
        else if (r < 87) o = 3'd5;
        else             o = 3'($urandom_range(0, 7));
        step(0, o, {$urandom, $urandom}, 2'($urandom_range(0, 3)), "rnd");
      end
    end
    step(0, 0, 0, 0, "drain");
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
